// File: rtl/kbd_event_writer_pkg.sv
// Shared types and constants for the keyboard event writer.
//   kbd_evt_t      : one key event {row, col, pressed}, 8 bits
//   kbd_state_e    : writer FSM states (the CLR_* states exist only when
//                    KBD_EVT_RELEASE_ALL_EN is defined)
//   wb_kbd_addr()  : Wishbone byte address of a keyboard matrix row register
package kbd_event_writer_pkg;

  localparam int KBD_ROW_COUNT      = 8;
  localparam int KBD_EVT_FIFO_DEPTH = 4;
  localparam int WB_ADDR_WIDTH      = 8;
  localparam int DATA_WIDTH         = 8;

  localparam logic [WB_ADDR_WIDTH-1:0] KBD_ROW_BASE = 8'h40;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] col;
    logic       pressed;
  } kbd_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
`ifdef KBD_EVT_RELEASE_ALL_EN
    ,
    ST_CLR_REQ,
    ST_CLR_WAIT
`endif
  } kbd_state_e;

  // Row registers are word-spaced above the matrix base address.
  function automatic logic [WB_ADDR_WIDTH-1:0] wb_kbd_addr(input logic [3:0] row);
    return KBD_ROW_BASE + {{(WB_ADDR_WIDTH-6){1'b0}}, row, 2'b00};
  endfunction

endpackage

// File: rtl/kbd_event_writer_fifo.sv
// Synchronous FIFO of kbd_evt_t events.
//   push_i/data_i  : write side; a push while full is taken only with a pop
//   pop_i/head_o   : head is combinational from storage, valid when !empty_o
//   flush_i        : discards stored entries; a same-cycle push survives
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module kbd_evt_fifo
  import kbd_event_writer_pkg::*;
#(
  parameter int DEPTH = KBD_EVT_FIFO_DEPTH
) (
  input  logic     wb_clock_i,
  input  logic     wb_reset_ni,
  input  logic     push_i,
  input  kbd_evt_t data_i,
  input  logic     pop_i,
  input  logic     flush_i,
  output kbd_evt_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  kbd_evt_t        mem_q [DEPTH];
  kbd_evt_t        mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && (!full_o || pop_i || flush_i);
    do_pop   = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = do_push ? CW'(1) : '0;
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kbd_event_writer.sv
// Keyboard event writer: buffers make/break events and applies each one to
// the keyboard matrix as an atomic Wishbone (pipelined) read-modify-write of
// the addressed row register. Keys are active-low.
//   evt_*         : event input, valid/ready handshake
//   wb_*          : Wishbone master towards the keyboard matrix
//   drop_o        : sticky, an event with row >= ROW_COUNT was discarded
//   busy_o        : FSM active or events still queued
// Optional: KBD_EVT_RELEASE_ALL_EN adds release_all_i, which (latched, taken
// at the next IDLE) flushes the FIFO and writes 8'hFF to every valid row.
//
// state    | meaning
// IDLE     | pop next event, discard out-of-range rows
// RD_REQ   | read strobe for the row register
// RD_WAIT  | wait read ack, compute new row value
// WR_REQ   | write strobe with modified value
// WR_WAIT  | wait write ack, end cycle
// CLR_REQ  | release-all write strobe (8'hFF) for row_q
// CLR_WAIT | wait ack, advance to next row
module kbd_event_writer
  import kbd_event_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = KBD_EVT_FIFO_DEPTH,
  parameter int ROW_COUNT  = KBD_ROW_COUNT
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic                     evt_valid_i,
  output logic                     evt_ready_o,
  input  logic [3:0]               evt_row_i,
  input  logic [2:0]               evt_col_i,
  input  logic                     evt_pressed_i,
`ifdef KBD_EVT_RELEASE_ALL_EN
  input  logic                     release_all_i,
`endif
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  output logic                     drop_o,
  output logic                     busy_o
);

  kbd_state_e              state_q, state_d;
  logic [3:0]              row_q, row_d;
  logic [2:0]              col_q, col_d;
  logic                    pressed_q, pressed_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    drop_q, drop_d;
  logic                    fifo_pop, fifo_flush, fifo_full, fifo_empty;
  kbd_evt_t                fifo_head, evt_in;
  logic [DATA_WIDTH-1:0]   col_mask, rmw_data;
  logic                    cyc, stb, we;
`ifdef KBD_EVT_RELEASE_ALL_EN
  logic                    clr_pend_q, clr_pend_d;
`endif

  assign evt_in = '{row: evt_row_i, col: evt_col_i, pressed: evt_pressed_i};

  kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clock_i  (wb_clock_i),
    .wb_reset_ni (wb_reset_ni),
    .push_i      (evt_valid_i && evt_ready_o),
    .data_i      (evt_in),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Active-low keys: a make clears the column bit, a break sets it.
  assign col_mask = DATA_WIDTH'(1) << col_q;
  assign rmw_data = pressed_q ? (wb_data_i & ~col_mask) : (wb_data_i | col_mask);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pressed_d  = pressed_q;
    data_d     = data_q;
    drop_d     = drop_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    cyc        = 1'b0;
    stb        = 1'b0;
    we         = 1'b0;
`ifdef KBD_EVT_RELEASE_ALL_EN
    clr_pend_d = clr_pend_q | release_all_i;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef KBD_EVT_RELEASE_ALL_EN
        if (clr_pend_q) begin
          fifo_flush = 1'b1;
          clr_pend_d = release_all_i;
          row_d      = '0;
          data_d     = '1;
          state_d    = ST_CLR_REQ;
        end else
`endif
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (int'(fifo_head.row) >= ROW_COUNT) begin
            drop_d = 1'b1;
          end else begin
            row_d     = fifo_head.row;
            col_d     = fifo_head.col;
            pressed_d = fifo_head.pressed;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (!wb_stall_i) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        cyc = 1'b1;
        if (wb_ack_i) begin
          // Unchanged row value: skip the write entirely.
          if (rmw_data == wb_data_i) begin
            state_d = ST_IDLE;
          end else begin
            data_d  = rmw_data;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        if (!wb_stall_i) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        cyc = 1'b1;
        we  = 1'b1;
        if (wb_ack_i) state_d = ST_IDLE;
      end
`ifdef KBD_EVT_RELEASE_ALL_EN
      ST_CLR_REQ: begin
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        if (!wb_stall_i) state_d = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        cyc = 1'b1;
        we  = 1'b1;
        if (wb_ack_i) begin
          if (int'(row_q) >= ROW_COUNT - 1) begin
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = ST_CLR_REQ;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pressed_q  <= 1'b0;
      data_q     <= '0;
      drop_q     <= 1'b0;
`ifdef KBD_EVT_RELEASE_ALL_EN
      clr_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pressed_q  <= pressed_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
`ifdef KBD_EVT_RELEASE_ALL_EN
      clr_pend_q <= clr_pend_d;
`endif
    end
  end

  // Address/data are forced to zero outside a cycle so the bus is quiet in IDLE.
  assign wb_cycle_o  = cyc;
  assign wb_strobe_o = stb;
  assign wb_we_o     = we;
  assign wb_addr_o   = cyc ? wb_kbd_addr(row_q) : '0;
  assign wb_data_o   = (cyc && we) ? data_q : '0;
  assign evt_ready_o = !fifo_full;
  assign drop_o      = drop_q;
`ifdef KBD_EVT_RELEASE_ALL_EN
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty || clr_pend_q;
`else
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
`endif

endmodule

// File: tb/tb_kbd_event_writer.sv
module tb_kbd_event_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid_i = 1'b0;
  logic        evt_ready_o;
  logic [3:0]  evt_row_i = '0;
  logic [2:0]  evt_col_i = '0;
  logic        evt_pressed_i = 1'b0;
`ifdef KBD_EVT_RELEASE_ALL_EN
  logic        release_all_i = 1'b0;
`endif
  logic [7:0]  wb_addr_o, wb_data_o;
  logic [7:0]  wb_data_i;
  logic        wb_we_o, wb_cycle_o, wb_strobe_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        drop_o, busy_o;
  logic        stall_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  kbd_event_writer dut (
    .wb_clock_i    (clk),
    .wb_reset_ni   (rst_n),
    .evt_valid_i   (evt_valid_i),
    .evt_ready_o   (evt_ready_o),
    .evt_row_i     (evt_row_i),
    .evt_col_i     (evt_col_i),
    .evt_pressed_i (evt_pressed_i),
`ifdef KBD_EVT_RELEASE_ALL_EN
    .release_all_i (release_all_i),
`endif
    .wb_addr_o     (wb_addr_o),
    .wb_data_o     (wb_data_o),
    .wb_data_i     (wb_data_i),
    .wb_we_o       (wb_we_o),
    .wb_cycle_o    (wb_cycle_o),
    .wb_strobe_o   (wb_strobe_o),
    .wb_stall_i    (wb_stall_i),
    .wb_ack_i      (wb_ack_i),
    .drop_o        (drop_o),
    .busy_o        (busy_o)
  );

  // Keyboard matrix slave model: rows at 8'h40 + 4*row, ack one cycle after accept.
  logic [7:0]  kbd_mem [16];
  logic [7:0]  slv_off;
  logic [3:0]  slv_row;
  int          rd_cnt = 0, wr_cnt = 0, cyc_cnt = 0, wr_ack_cyc = 0;
  logic [15:0] wlog [$];

  assign wb_stall_i = stall_en;
  assign slv_off    = wb_addr_o - 8'h40;
  assign slv_row    = slv_off[5:2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i  <= 1'b0;
      wb_data_i <= 8'h00;
      for (int i = 0; i < 16; i++) kbd_mem[i] <= 8'hFF;
    end else begin
      wb_ack_i <= 1'b0;
      if (wb_cycle_o && wb_strobe_o && !wb_stall_i) begin
        wb_ack_i <= 1'b1;
        if (wb_we_o) begin
          kbd_mem[slv_row] <= wb_data_o;
          wr_cnt <= wr_cnt + 1;
          wlog.push_back({wb_addr_o, wb_data_o});
        end else begin
          wb_data_i <= kbd_mem[slv_row];
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (wb_ack_i && wb_cycle_o && wb_we_o) wr_ack_cyc <= cyc_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int acc_cyc = 0;

  task automatic push_evt(input logic [3:0] r, input logic [2:0] c, input logic p);
    int w;
    w = 0;
    @(negedge clk);
    evt_row_i = r; evt_col_i = c; evt_pressed_i = p; evt_valid_i = 1'b1;
    while (!evt_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", evt_ready_o, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc_cnt;
    evt_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", busy_o, 0);
  endtask

  int r0, w0, n0, acc, w;
  logic rdy;
  logic [7:0] exp_seq [5];

  initial begin
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFC; exp_seq[2] = 8'hF8;
    exp_seq[3] = 8'hF0; exp_seq[4] = 8'hE0;

    #12;
    check("rst_ready", evt_ready_o, 1);
    check("rst_cyc", wb_cycle_o, 0);
    check("rst_stb", wb_strobe_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // press row 3 col 5
    r0 = rd_cnt;
    push_evt(4'd3, 3'd5, 1'b1);
    wait_idle();
    check("press_r3", kbd_mem[3], 8'hDF);
    check("press_latency", wr_ack_cyc - acc_cyc, 5);
    check("press_wlog", wlog[wlog.size()-1], 16'h4CDF);
    check("press_reads", rd_cnt - r0, 1);

    // release, then redundant release
    push_evt(4'd3, 3'd5, 1'b0);
    wait_idle();
    check("release_r3", kbd_mem[3], 8'hFF);
    r0 = rd_cnt; w0 = wr_cnt;
    push_evt(4'd3, 3'd5, 1'b0);
    wait_idle();
    check("redundant_reads", rd_cnt - r0, 1);
    check("redundant_writes", wr_cnt - w0, 0);
    check("redundant_r3", kbd_mem[3], 8'hFF);

    // stalled slave: FIFO fills behind the stuck read
    n0 = wlog.size();
    stall_en = 1'b1;
    push_evt(4'd1, 3'd0, 1'b1);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      evt_row_i = 4'd1; evt_col_i = 3'(acc + 1); evt_pressed_i = 1'b1; evt_valid_i = 1'b1;
      rdy = evt_ready_o;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    evt_valid_i = 1'b0;
    check("stall_accepted", acc, 4);
    check("stall_ready", evt_ready_o, 0);
    check("stall_rd_strobe", {wb_cycle_o, wb_strobe_o, wb_we_o}, 3'b110);
    stall_en = 1'b0;
    wait_idle();
    for (int k = 0; k < 5; k++) check("stall_order", wlog[n0 + k], {8'h44, exp_seq[k]});
    check("stall_r1", kbd_mem[1], 8'hE0);
    check("stall_ready_back", evt_ready_o, 1);

    // out-of-range row
    r0 = rd_cnt; w0 = wr_cnt;
    push_evt(4'd8, 3'd0, 1'b1);
    repeat (5) @(negedge clk);
    check("drop_reads", rd_cnt - r0, 0);
    check("drop_writes", wr_cnt - w0, 0);
    check("drop_flag", drop_o, 1);
    push_evt(4'd0, 3'd0, 1'b1);
    wait_idle();
    check("after_drop_r0", kbd_mem[0], 8'hFE);
    check("drop_sticky", drop_o, 1);

    // reset during WR_REQ with an event still queued
    push_evt(4'd2, 3'd0, 1'b1);
    w = 0;
    while (!(wb_cycle_o && !wb_strobe_o && !wb_we_o) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reach_rd_wait", {wb_cycle_o, wb_strobe_o, wb_we_o}, 3'b100);
    stall_en = 1'b1;
    push_evt(4'd2, 3'd1, 1'b1);
    check("in_wr_req", {wb_cycle_o, wb_strobe_o, wb_we_o}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", wb_cycle_o, 0);
    check("arst_stb", wb_strobe_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_ready", evt_ready_o, 1);
    check("arst_drop", drop_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_en = 1'b0;
    push_evt(4'd2, 3'd1, 1'b1);
    wait_idle();
    check("post_rst_r2", kbd_mem[2], 8'hFD);

`ifdef KBD_EVT_RELEASE_ALL_EN
    push_evt(4'd1, 3'd2, 1'b1);
    push_evt(4'd7, 3'd4, 1'b1);
    wait_idle();
    check("pre_clr_r7", kbd_mem[7], 8'hEF);
    r0 = rd_cnt; w0 = wr_cnt; n0 = wlog.size();
    @(negedge clk);
    release_all_i = 1'b1;
    @(negedge clk);
    release_all_i = 1'b0;
    wait_idle();
    check("clr_writes", wr_cnt - w0, 8);
    check("clr_reads", rd_cnt - r0, 0);
    for (int k = 0; k < 8; k++) begin
      check("clr_row", kbd_mem[k], 8'hFF);
      check("clr_order", wlog[n0 + k], {8'(8'h40 + 4 * k), 8'hFF});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
